// File: rtl/mean_stream_filter.sv
// Streaming 3x3 mean filter (or centre-pixel bypass) for raster-order frames, fixed 3-cycle latency.
// Optional macro MEAN_ROUND_EN: round-to-nearest mean instead of truncation.
module mean_stream_filter #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240
) (
    input  logic              clk_i_mean,
    input  logic              rst_i_mean,
    input  logic              valid_i,
    input  logic              sof_i,
    input  logic              mode_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              done_o,
    output logic              err_o
);
    // state    | meaning
    // WAIT_SOF | idle between frames; pixels without sof_i are rejected and flag an error
    // ACTIVE   | frame in progress; row/col track the next expected pixel
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int SW = DATA_W + 4;

    typedef enum logic {WAIT_SOF, ACTIVE} state_t;

    state_t state_q, state_d;
    logic [CW-1:0] col_q, col_d, pix_col;
    logic [RW-1:0] row_q, row_d, pix_row;
    logic accept, restart, frame_err, last_pix, win_valid;

    always_ff @(posedge clk_i_mean) begin
        if (rst_i_mean) begin
            state_q <= WAIT_SOF;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        accept    = 1'b0;
        restart   = 1'b0;
        frame_err = 1'b0;
        pix_col   = col_q;
        pix_row   = row_q;
        if (valid_i) begin
            if (sof_i) begin
                accept    = 1'b1;
                pix_col   = '0;
                pix_row   = '0;
                restart   = (state_q == ACTIVE);
                frame_err = (state_q == ACTIVE);
            end else if (state_q == ACTIVE) begin
                accept = 1'b1;
            end else begin
                frame_err = 1'b1;
            end
        end
        last_pix  = accept && (pix_row == RW'(IMG_H-1)) && (pix_col == CW'(IMG_W-1));
        win_valid = accept && (pix_row >= RW'(2)) && (pix_col >= CW'(2));
        if (accept) begin
            if (pix_col == CW'(IMG_W-1)) begin
                col_d = '0;
                row_d = last_pix ? '0 : pix_row + 1'b1;
            end else begin
                col_d = pix_col + 1'b1;
                row_d = pix_row;
            end
            state_d = last_pix ? WAIT_SOF : ACTIVE;
        end
    end

    // line_a holds the row two above the current pixel, line_b the row directly above
    logic [DATA_W-1:0] line_a [IMG_W];
    logic [DATA_W-1:0] line_b [IMG_W];
    logic [DATA_W-1:0] w_top [3];
    logic [DATA_W-1:0] w_mid [3];
    logic [DATA_W-1:0] w_bot [3];

    always_ff @(posedge clk_i_mean) begin
        if (accept) begin
            line_a[pix_col] <= line_b[pix_col];
            line_b[pix_col] <= data_i;
            for (int i = 0; i < 2; i++) begin
                w_top[i] <= w_top[i+1];
                w_mid[i] <= w_mid[i+1];
                w_bot[i] <= w_bot[i+1];
            end
            w_top[2] <= line_a[pix_col];
            w_mid[2] <= line_b[pix_col];
            w_bot[2] <= data_i;
        end
    end

    logic              s1_valid, s1_mode, s1_last;
    logic              s2_valid, s2_mode, s2_last;
    logic [SW-1:0]     sum_c, s2_sum;
    logic [DATA_W-1:0] s2_centre, mean_c;

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < 3; i++) begin
            sum_c = sum_c + SW'(w_top[i]) + SW'(w_mid[i]) + SW'(w_bot[i]);
        end
    end

    always_comb begin
`ifdef MEAN_ROUND_EN
        mean_c = DATA_W'((s2_sum + SW'(4)) / SW'(9));
`else
        mean_c = DATA_W'(s2_sum / SW'(9));
`endif
    end

    // A restart kills everything not yet presented on the outputs
    always_ff @(posedge clk_i_mean) begin
        if (rst_i_mean) begin
            s1_valid  <= 1'b0;
            s1_mode   <= 1'b0;
            s1_last   <= 1'b0;
            s2_valid  <= 1'b0;
            s2_mode   <= 1'b0;
            s2_last   <= 1'b0;
            s2_sum    <= '0;
            s2_centre <= '0;
            data_o    <= '0;
            valid_o   <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            s1_valid  <= win_valid;
            s1_mode   <= mode_i;
            s1_last   <= last_pix;
            s2_valid  <= s1_valid & ~restart;
            s2_mode   <= s1_mode;
            s2_last   <= s1_last;
            s2_sum    <= sum_c;
            s2_centre <= w_mid[1];
            valid_o   <= s2_valid & ~restart;
            done_o    <= s2_valid & s2_last & ~restart;
            err_o     <= err_o | frame_err;
            if (s2_valid && !restart) begin
                data_o <= s2_mode ? s2_centre : mean_c;
            end
        end
    end
endmodule

// File: tb/tb_mean_stream_filter.sv
// Self-checking bench for mean_stream_filter (8x6 frames) against a queue-based window reference model.
module tb_mean_stream_filter;
    localparam int W = 8;
    localparam int H = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_i = 1'b0;
    logic       sof_i = 1'b0;
    logic       mode_i = 1'b0;
    logic [7:0] data_i = 8'd0;
    logic [7:0] data_o;
    logic       valid_o, done_o, err_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_out = 0;
    int base = 0;
    int img [H][W];
    int mr = 0;
    int mc = 0;
    logic in_frame = 1'b0;
    logic err_exp = 1'b0;

    typedef struct {
        int   due;
        int   val;
        logic last;
    } exp_t;
    exp_t q[$];

    mean_stream_filter #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk_i_mean(clk),
        .rst_i_mean(rst),
        .valid_i(valid_i),
        .sof_i(sof_i),
        .mode_i(mode_i),
        .data_i(data_i),
        .data_o(data_o),
        .valid_o(valid_o),
        .done_o(done_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int win_val(input int r, input int c, input logic m);
        int s = 0;
        if (m) return img[r-1][c-1];
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                s += img[r-2+dr][c-2+dc];
`ifdef MEAN_ROUND_EN
        return (s + 4) / 9;
`else
        return s / 9;
`endif
    endfunction

    function automatic logic [7:0] pix(input int kind, input int r, input int c);
        case (kind)
            0:       return 8'd100;
            1:       return 8'(c);
            2:       return (r == 3 && c == 3) ? 8'd9 : 8'd1;
            3:       return 8'd255;
            4:       return 8'(r * W + c);
            default: return 8'($urandom_range(255, 0));
        endcase
    endfunction

    task automatic tick(input logic v, input logic s, input logic m, input logic [7:0] d);
        exp_t e;
        logic ev, el;
        int ed;
        valid_i = v;
        sof_i   = s;
        mode_i  = m;
        data_i  = d;
        @(posedge clk);
        cyc++;
        if (rst) begin
            q.delete();
            in_frame = 1'b0;
            err_exp  = 1'b0;
        end else if (v) begin
            if (s) begin
                if (in_frame) begin
                    err_exp = 1'b1;
                    while (q.size() > 0 && q[$].due >= cyc) void'(q.pop_back());
                end
                in_frame = 1'b1;
                mr = 0;
                mc = 0;
            end else if (!in_frame) begin
                err_exp = 1'b1;
            end
            if (in_frame) begin
                img[mr][mc] = int'(d);
                if (mr >= 2 && mc >= 2) begin
                    e.due  = cyc + 2;
                    e.val  = win_val(mr, mc, m);
                    e.last = (mr == H-1 && mc == W-1);
                    q.push_back(e);
                end
                if (mc == W-1) begin
                    mc = 0;
                    if (mr == H-1) begin
                        mr = 0;
                        in_frame = 1'b0;
                    end else mr++;
                end else mc++;
            end
        end
        #1;
        ev = 1'b0;
        el = 1'b0;
        ed = 0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e  = q.pop_front();
            ev = 1'b1;
            ed = e.val;
            el = e.last;
            n_out++;
        end
        check("valid_o", valid_o, ev);
        if (ev) check("data_o", data_o, ed);
        if (rst) check("data_o_rst", data_o, 0);
        check("done_o", done_o, el);
        check("err_o", err_o, err_exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic send_frame(input int kind, input int npix, input bit gaps, input int mode_kind);
        logic m;
        for (int i = 0; i < npix; i++) begin
            if (gaps)
                for (int g = 0; g < 3 && $urandom_range(1, 0) == 1; g++)
                    tick(1'b0, 1'b0, 1'($urandom_range(1, 0)), 8'($urandom_range(255, 0)));
            m = (mode_kind == 2) ? 1'($urandom_range(1, 0)) : 1'(mode_kind);
            tick(1'b1, i == 0, m, pix(kind, i / W, i % W));
        end
    endtask

    initial begin
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);

        // pixels before any sof_i are ignored and flag an error; reset clears it
        tick(1'b1, 1'b0, 1'b0, 8'd50);
        tick(1'b1, 1'b0, 1'b0, 8'd60);
        idle(2);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);

        // constant frame followed immediately by a column-ramp frame (sof right after last pixel)
        base = n_out;
        send_frame(0, W*H, 1'b0, 0);
        send_frame(1, W*H, 1'b0, 0);
        idle(6);
        check("two_frames_count", n_out - base, 48);

        base = n_out;
        send_frame(2, W*H, 1'b0, 0);
        idle(6);
        check("sum17_count", n_out - base, 24);

        base = n_out;
        send_frame(3, W*H, 1'b0, 0);
        idle(6);
        check("all255_count", n_out - base, 24);

        base = n_out;
        send_frame(4, W*H, 1'b0, 1);
        idle(6);
        check("bypass_count", n_out - base, 24);

        base = n_out;
        send_frame(5, W*H, 1'b1, 0);
        idle(6);
        check("gaps_count", n_out - base, 24);

        base = n_out;
        send_frame(5, W*H, 1'b1, 2);
        idle(6);
        check("gaps_mode_count", n_out - base, 24);

        // abort: new sof arrives where pixel (3,4) was due
        send_frame(5, 3*W + 4, 1'b0, 0);
        base = n_out;
        send_frame(5, W*H, 1'b0, 2);
        idle(6);
        check("abort_new_frame_count", n_out - base, 24);

        // reset mid-frame discards everything in flight
        send_frame(5, 30, 1'b0, 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(5);

        base = n_out;
        send_frame(5, W*H, 1'b0, 0);
        idle(6);
        check("post_reset_count", n_out - base, 24);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
